mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Next-generation multicycle control unit for the MCU-32X CPU core.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a registered instruction register (IR).
- Adds ready/valid instruction fetch, a wait-stated data-memory handshake with timeout, a global stall, an extended opcode set (bne, jal, addi), illegal-opcode fault, and a retired-instruction counter.
- Sits between the instruction/data memory interfaces and the datapath (ALU, register file, PC).

Parameters:
- XLEN, 32, instruction/counter width.
- ALU_CTRL_W, 4, width of alu_control; R-type passes funct[ALU_CTRL_W-1:0].
- TIMEOUT_MAX, 15, maximum consecutive MEMORY cycles without mem_ready before fault (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  XLEN  fetched instruction.
- instr_valid  in  1  instr_in valid.
- instr_ready  out  1  FSM accepts instruction.
- mem_ready  in  1  data memory completes current access.
- branch_cond  in  1  ALU compare result (1 = operands equal).
- stall_in  in  1  freeze request.
- ir_out  out  XLEN  latched instruction.
- pc_inc  out  1  PC+4 strobe.
- pc_write  out  1  load PC with branch/jump target.
- alu_control  out  ALU_CTRL_W  ALU operation.
- alu_src_imm  out  1  ALU B operand = immediate.
- reg_write  out  1  register-file write strobe.
- mem_read  out  1  data load request.
- mem_write  out  1  data store request.
- branch  out  1  branch instruction in EXECUTE.
- jump  out  1  jump instruction in EXECUTE.
- link  out  1  writeback selects PC (jal).
- state_out  out  3  current state encoding.
- fault  out  1  sticky fault flag.
- retired_count  out  XLEN  instructions retired, wraps at 2^XLEN.

Behaviour:
- Reset (synchronous): state=FETCH, IR=0, timeout counter=0, fault=0, retired_count=0. All strobes are 0 during and after reset, except instr_ready (1 in FETCH when not stalled).
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, FAULT=5. Codes 6/7 go to FAULT.
- Outputs are combinational from state, IR and stall_in. All defaults are 0.
- FETCH:
  - instr_ready = !stall_in.
  - On instr_valid & instr_ready: IR<=instr_in, pc_inc=1 that cycle, next state DECODE. Otherwise hold.
- DECODE: one cycle. Opcode IR[31:26] decodes as:
  - R=000000, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, jal=000011, addi=001000.
  - Any other opcode -> FAULT; otherwise -> EXECUTE.
- EXECUTE: one cycle.
  - R-type: alu_control=IR[ALU_CTRL_W-1:0]; next WRITEBACK.
  - addi/lw/sw: alu_control=ALU_ADD, alu_src_imm=1. addi -> WRITEBACK; lw/sw -> MEMORY.
  - beq/bne: alu_control=ALU_SUB, branch=1, pc_write = branch_cond (beq) or !branch_cond (bne); next FETCH.
  - j: jump=1, pc_write=1; next FETCH.
  - jal: jump=1, pc_write=1; next WRITEBACK.
- MEMORY:
  - mem_read (lw) or mem_write (sw) is held high until mem_ready is sampled high.
  - On mem_ready: lw -> WRITEBACK, sw -> FETCH; counter clears.
  - Each cycle without mem_ready increments the counter. When the counter equals TIMEOUT_MAX with mem_ready low -> FAULT.
  - mem_ready in the same cycle the counter reaches TIMEOUT_MAX counts as success.
- WRITEBACK: reg_write=1 for exactly one cycle; link=1 if jal; next FETCH.
- Retire:
  - Every transition into FETCH from EXECUTE, MEMORY or WRITEBACK increments retired_count by 1, wrapping at all-ones to 0.
  - FAULT never increments it.
- FAULT: fault=1; all strobes 0, instr_ready=0. Exit only by reset.
- stall_in=1 in any non-FAULT state:
  - State, IR and counter hold.
  - instr_ready, pc_inc, pc_write, reg_write, mem_read, mem_write, ir load and retire are all suppressed.
  - alu_control, branch, jump and link still reflect the held state.
  - Stall has priority over mem_ready and instr_valid in the same cycle.
- Reset asserted mid-operation (any state, including MEMORY wait) returns to the reset values on the next edge. Any pending memory request drops immediately.

Decomposition:
- Package mc_ctrl_pkg: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI), ALU_ADD=4'b0010, ALU_SUB=4'b0110.
- One combinational sub-module, mc_opcode_decode: IR to instruction class, legality and alu_control. The FSM, counter and retire logic stay in the top module.

Test Plan:
- Reset, then R-type 0x00221820 with instr_valid=1:
  - Expected states 0->1->2->4->0.
  - alu_control=4'h0 in EXECUTE; reg_write high exactly one cycle; retired_count=1.
- lw with mem_ready held low 3 cycles then high:
  - mem_read high for 4 MEMORY cycles, then WRITEBACK with reg_write=1.
  - sw with immediate mem_ready returns to FETCH with no reg_write.
- beq with branch_cond=1: pc_write=1 in EXECUTE. bne with branch_cond=1: pc_write=0. Both return to FETCH after 3 cycles; retired_count +2.
- jal: jump=1 and pc_write=1 in EXECUTE, then link=1 and reg_write=1 in WRITEBACK. Illegal opcode 0x3F: FAULT after DECODE, fault=1 sticky until reset.
- lw with mem_ready never asserted and TIMEOUT_MAX=15: FAULT after 16 MEMORY cycles. Repeat with mem_ready on the final cycle: completes, no fault.
- Stall and reset cases:
  - stall_in=1 for 5 cycles in MEMORY while mem_ready=1: state holds and mem_read=0; on release, completes the next cycle.
  - Reset pulse during MEMORY: state_out=0, retired_count=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation codes and the decoded instruction classes.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      StFetch     = 3'd0,
      StDecode    = 3'd1,
      StExecute   = 3'd2,
      StMemory    = 3'd3,
      StWriteback = 3'd4,
      StFault     = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ClsR,
      ClsLw,
      ClsSw,
      ClsBeq,
      ClsBne,
      ClsJ,
      ClsJal,
      ClsAddi
   } instr_class_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // Wide enough for any timeout limit up to 255.
   localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Instruction-fetch, data-memory and datapath control bundle of the control unit.
// slave = control unit side, master = memory/datapath side.
interface mc_control_fsm_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ALU_CTRL_W = 4
);
   logic [XLEN-1:0]       instr_in;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  mem_ready;
   logic                  branch_cond;
   logic                  stall_in;
   logic [XLEN-1:0]       ir_out;
   logic                  pc_inc;
   logic                  pc_write;
   logic [ALU_CTRL_W-1:0] alu_control;
   logic                  alu_src_imm;
   logic                  reg_write;
   logic                  mem_read;
   logic                  mem_write;
   logic                  branch;
   logic                  jump;
   logic                  link;
   logic [2:0]            state_out;
   logic                  fault;
   logic [XLEN-1:0]       retired_count;

   modport slave (
      input  instr_in, instr_valid, mem_ready, branch_cond, stall_in,
      output instr_ready, ir_out, pc_inc, pc_write, alu_control, alu_src_imm, reg_write,
             mem_read, mem_write, branch, jump, link, state_out, fault, retired_count
   );

   modport master (
      output instr_in, instr_valid, mem_ready, branch_cond, stall_in,
      input  instr_ready, ir_out, pc_inc, pc_write, alu_control, alu_src_imm, reg_write,
             mem_read, mem_write, branch, jump, link, state_out, fault, retired_count
   );
endinterface

// File: rtl/mc_opcode_decode.sv
// Purely combinational opcode decoder: instruction class, legality and ALU operation.
module mc_opcode_decode
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned ALU_CTRL_W = 4
) (
   input  logic [5:0]            opcode_i,
   input  logic [ALU_CTRL_W-1:0] funct_i,
   output instr_class_e          cls_o,
   output logic                  legal_o,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

   // Map the opcode field onto a class and the ALU operation used in EXECUTE
   always_comb begin
      cls_o      = ClsR;
      legal_o    = 1'b1;
      alu_ctrl_o = '0;
      case (opcode_i)
         OP_RTYPE: begin
            cls_o      = ClsR;
            alu_ctrl_o = funct_i;
         end
         OP_LW: begin
            cls_o      = ClsLw;
            alu_ctrl_o = ALU_CTRL_W'(ALU_ADD);
         end
         OP_SW: begin
            cls_o      = ClsSw;
            alu_ctrl_o = ALU_CTRL_W'(ALU_ADD);
         end
         OP_ADDI: begin
            cls_o      = ClsAddi;
            alu_ctrl_o = ALU_CTRL_W'(ALU_ADD);
         end
         OP_BEQ: begin
            cls_o      = ClsBeq;
            alu_ctrl_o = ALU_CTRL_W'(ALU_SUB);
         end
         OP_BNE: begin
            cls_o      = ClsBne;
            alu_ctrl_o = ALU_CTRL_W'(ALU_SUB);
         end
         OP_J:    cls_o = ClsJ;
         OP_JAL:  cls_o = ClsJal;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with
// ready/valid fetch, timed-out memory handshake, global stall, sticky fault and
// retired-instruction counter.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned ALU_CTRL_W  = 4,
   parameter int unsigned TIMEOUT_MAX = 15
) (
   input logic            clk,
   input logic            reset,
   mc_control_fsm_if.slave bus
);

   state_e                state_q, state_d;
   logic [XLEN-1:0]       ir_q, ir_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic [XLEN-1:0]       retired_q, retired_d;

   instr_class_e          dec_cls;
   logic                  dec_legal;
   logic [ALU_CTRL_W-1:0] dec_alu;
   logic                  strobe_en;

   mc_opcode_decode #(
      .ALU_CTRL_W(ALU_CTRL_W)
   ) u_decode (
      .opcode_i  (ir_q[XLEN-1 -: 6]),
      .funct_i   (ir_q[ALU_CTRL_W-1:0]),
      .cls_o     (dec_cls),
      .legal_o   (dec_legal),
      .alu_ctrl_o(dec_alu)
   );

   // Strobes drop during stall and also while reset is asserted, so a pending
   // memory request is withdrawn in the same cycle reset arrives.
   assign strobe_en = !bus.stall_in && !reset;

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         ir_q      <= '0;
         tmo_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         tmo_q     <= tmo_d;
         retired_q <= retired_d;
      end
   end

   // Next-state, IR load, memory timeout and retire logic; stall freezes everything
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      tmo_d     = tmo_q;
      retired_d = retired_q;
      case (state_q)
         StFetch: begin
            if (!bus.stall_in && bus.instr_valid) begin
               ir_d    = bus.instr_in;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (!bus.stall_in) state_d = dec_legal ? StExecute : StFault;
         end
         StExecute: begin
            if (!bus.stall_in) begin
               case (dec_cls)
                  ClsR, ClsAddi, ClsJal: state_d = StWriteback;
                  ClsLw, ClsSw:          state_d = StMemory;
                  default:               state_d = StFetch;
               endcase
            end
         end
         StMemory: begin
            if (!bus.stall_in) begin
               if (bus.mem_ready) begin
                  state_d = (dec_cls == ClsLw) ? StWriteback : StFetch;
                  tmo_d   = '0;
               end else if (tmo_q == TMO_W'(TIMEOUT_MAX)) begin
                  state_d = StFault;
                  tmo_d   = '0;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
         end
         StWriteback: begin
            if (!bus.stall_in) state_d = StFetch;
         end
         StFault: state_d = StFault;
         default: state_d = StFault;
      endcase

      if (state_d == StFetch && state_q inside {StExecute, StMemory, StWriteback}) begin
         retired_d = retired_q + XLEN'(1);
      end
   end

   // Output decode: strobes gated by strobe_en, status fields follow the held state
   always_comb begin
      bus.instr_ready = 1'b0;
      bus.pc_inc      = 1'b0;
      bus.pc_write    = 1'b0;
      bus.alu_control = '0;
      bus.alu_src_imm = 1'b0;
      bus.reg_write   = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.branch      = 1'b0;
      bus.jump        = 1'b0;
      bus.link        = 1'b0;
      bus.fault       = 1'b0;
      case (state_q)
         StFetch: begin
            bus.instr_ready = !bus.stall_in;
            bus.pc_inc      = strobe_en && bus.instr_valid;
         end
         StExecute: begin
            bus.alu_control = dec_alu;
            case (dec_cls)
               ClsAddi, ClsLw, ClsSw: bus.alu_src_imm = 1'b1;
               ClsBeq: begin
                  bus.branch   = 1'b1;
                  bus.pc_write = strobe_en && bus.branch_cond;
               end
               ClsBne: begin
                  bus.branch   = 1'b1;
                  bus.pc_write = strobe_en && !bus.branch_cond;
               end
               ClsJ, ClsJal: begin
                  bus.jump     = 1'b1;
                  bus.pc_write = strobe_en;
               end
               default: ;
            endcase
         end
         StMemory: begin
            bus.mem_read  = strobe_en && (dec_cls == ClsLw);
            bus.mem_write = strobe_en && (dec_cls == ClsSw);
         end
         StWriteback: begin
            bus.reg_write = strobe_en;
            bus.link      = (dec_cls == ClsJal);
         end
         StFault: bus.fault = 1'b1;
         default: ;
      endcase
   end

   assign bus.ir_out        = ir_q;
   assign bus.state_out     = state_q;
   assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: a transaction-level model expands each
// instruction into per-cycle {inputs, expected outputs} rows, which are then
// applied in order; a hand-written stall-in-memory sequence follows.
module tb_mc_control_fsm;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        valid;
      logic        mrdy;
      logic        bc;
      logic [31:0] instr;
      logic [2:0]  st;
      logic        ird;
      logic        pcinc;
      logic        pcw;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        imm;
      logic        br;
      logic        jmp;
      logic        lnk;
      logic        flt;
      logic [3:0]  alu;
      logic [31:0] ret;
      logic [31:0] ir;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mc_control_fsm_if #(.XLEN(32), .ALU_CTRL_W(4)) bus ();

   mc_control_fsm #(
      .XLEN       (32),
      .ALU_CTRL_W (4),
      .TIMEOUT_MAX(15)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   vec_t        vq[$];
   logic [31:0] m_ret;
   logic [31:0] m_ir;
   bit          stall_en;
   int          n_checks;
   int          n_errors;
   int          row;

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI};
   endfunction

   function automatic vec_t mk(input logic [2:0] st);
      vec_t v;
      v     = '0;
      v.st  = st;
      v.ird = (st == 3'd0);
      v.flt = (st == 3'd5);
      v.ret = m_ret;
      v.ir  = m_ir;
      return v;
   endfunction

   // Append a row, optionally preceded by stalled copies of the same cycle.
   task automatic push(input vec_t v);
      vec_t s;
      int   k;
      if (stall_en && !v.rst && $urandom_range(0, 3) == 0) begin
         k = $urandom_range(1, 3);
         for (int i = 0; i < k; i++) begin
            s       = v;
            s.stall = 1'b1;
            s.ird   = 1'b0;
            s.pcinc = 1'b0;
            s.pcw   = 1'b0;
            s.rw    = 1'b0;
            s.mr    = 1'b0;
            s.mw    = 1'b0;
            s.mrdy  = 1'($urandom);
            s.valid = 1'($urandom);
            vq.push_back(s);
         end
      end
      vq.push_back(v);
   endtask

   // A few cycles parked in FAULT, then a reset that clears everything.
   task automatic fault_tail();
      vec_t v;
      for (int i = 0; i < 3; i++) begin
         v       = mk(3'd5);
         v.valid = 1'b1;
         v.mrdy  = 1'($urandom);
         push(v);
      end
      v     = mk(3'd5);
      v.rst = 1'b1;
      push(v);
      m_ret = '0;
      m_ir  = '0;
   endtask

   // Expand one instruction into its expected cycle sequence.
   // waits: MEMORY cycles before mem_ready (>15 means never); rst_mem: reset in
   // that MEMORY cycle (-1 for none).
   task automatic gen_instr(input logic [31:0] instr, input int waits, input logic bc,
                            input int rst_mem);
      logic [5:0] op;
      vec_t       v;
      op      = instr[31:26];
      v       = mk(3'd0);
      v.instr = instr;
      v.valid = 1'b1;
      v.pcinc = 1'b1;
      push(v);
      m_ir = instr;
      push(mk(3'd1));
      if (!is_legal(op)) begin
         fault_tail();
         return;
      end
      v    = mk(3'd2);
      v.bc = bc;
      case (op)
         OP_R:                   v.alu = instr[3:0];
         OP_ADDI, OP_LW, OP_SW: begin v.alu = 4'b0010; v.imm = 1'b1; end
         OP_BEQ:                begin v.alu = 4'b0110; v.br = 1'b1; v.pcw = bc; end
         OP_BNE:                begin v.alu = 4'b0110; v.br = 1'b1; v.pcw = !bc; end
         default:               begin v.jmp = 1'b1; v.pcw = 1'b1; end
      endcase
      push(v);
      if (op inside {OP_BEQ, OP_BNE, OP_J}) begin
         m_ret = m_ret + 1;
         return;
      end
      if (op == OP_LW || op == OP_SW) begin
         for (int i = 0; i < 16; i++) begin
            v      = mk(3'd3);
            v.mr   = (op == OP_LW);
            v.mw   = (op == OP_SW);
            v.mrdy = (i == waits);
            if (i == rst_mem) begin
               v.rst  = 1'b1;
               v.mr   = 1'b0;
               v.mw   = 1'b0;
               v.mrdy = 1'b0;
               push(v);
               m_ret = '0;
               m_ir  = '0;
               return;
            end
            push(v);
            if (i == waits) break;
         end
         if (waits > 15) begin
            fault_tail();
            return;
         end
         if (op == OP_SW) begin
            m_ret = m_ret + 1;
            return;
         end
      end
      v     = mk(3'd4);
      v.rw  = 1'b1;
      v.lnk = (op == OP_JAL);
      push(v);
      m_ret = m_ret + 1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
      end
   endtask

   // Drive one row just after a rising edge, compare on the falling edge.
   task automatic apply(input vec_t v);
      logic [10:0] act_s;
      logic [10:0] exp_s;
      reset           = v.rst;
      bus.instr_in    = v.instr;
      bus.instr_valid = v.valid;
      bus.mem_ready   = v.mrdy;
      bus.branch_cond = v.bc;
      bus.stall_in    = v.stall;
      @(negedge clk);
      act_s = {bus.instr_ready, bus.pc_inc, bus.pc_write, bus.reg_write, bus.mem_read,
               bus.mem_write, bus.alu_src_imm, bus.branch, bus.jump, bus.link, bus.fault};
      exp_s = {v.ird, v.pcinc, v.pcw, v.rw, v.mr, v.mw, v.imm, v.br, v.jmp, v.lnk, v.flt};
      check("state_out", 32'(bus.state_out), 32'(v.st));
      check("strobes{ird,pcinc,pcw,rw,mr,mw,imm,br,jmp,lnk,flt}", 32'(act_s), 32'(exp_s));
      check("alu_control", 32'(bus.alu_control), 32'(v.alu));
      check("retired_count", bus.retired_count, v.ret);
      check("ir_out", bus.ir_out, v.ir);
      row++;
      @(posedge clk);
      #1;
   endtask

   // Hand-written: stall for five MEMORY cycles with mem_ready high, then release.
   task automatic hand_stall_mem();
      vec_t v;
      v       = mk(3'd0);
      v.instr = 32'h8C22_0008;
      v.valid = 1'b1;
      v.pcinc = 1'b1;
      apply(v);
      m_ir = 32'h8C22_0008;
      apply(mk(3'd1));
      v     = mk(3'd2);
      v.alu = 4'b0010;
      v.imm = 1'b1;
      apply(v);
      for (int i = 0; i < 5; i++) begin
         v       = mk(3'd3);
         v.stall = 1'b1;
         v.mrdy  = 1'b1;
         apply(v);
      end
      v      = mk(3'd3);
      v.mr   = 1'b1;
      v.mrdy = 1'b1;
      apply(v);
      v    = mk(3'd4);
      v.rw = 1'b1;
      apply(v);
      m_ret = m_ret + 1;
      apply(mk(3'd0));
   endtask

   initial begin
      logic [5:0]  op;
      logic [5:0]  ops[8];
      logic [31:0] ins;
      int          pick;
      int          w;
      n_checks = 0;
      n_errors = 0;
      row      = 0;
      m_ret    = '0;
      m_ir     = '0;
      ops      = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI};

      // Directed table following the test plan.
      stall_en = 1'b0;
      push(mk(3'd0));
      gen_instr(32'h0022_1820, 0, 1'b0, -1);
      gen_instr(32'h8C22_0004, 3, 1'b0, -1);
      gen_instr(32'hAC22_0004, 0, 1'b0, -1);
      gen_instr(32'h1022_0003, 0, 1'b1, -1);
      gen_instr(32'h1422_0003, 0, 1'b1, -1);
      gen_instr(32'h0C00_0010, 0, 1'b0, -1);
      gen_instr(32'h0800_0010, 0, 1'b0, -1);
      gen_instr(32'h2022_0005, 0, 1'b0, -1);
      gen_instr(32'hFC00_0000, 0, 1'b0, -1);
      push(mk(3'd0));
      gen_instr(32'h8C22_0004, 20, 1'b0, -1);
      gen_instr(32'h8C22_0004, 15, 1'b0, -1);
      gen_instr(32'h0022_1825, 0, 1'b0, -1);
      gen_instr(32'hAC22_0004, 6, 1'b0, 2);
      push(mk(3'd0));

      // Randomized instruction stream with random stalls and wait states.
      stall_en = 1'b1;
      for (int n = 0; n < 40; n++) begin
         pick = $urandom_range(0, 9);
         if (pick == 9) begin
            ins = $urandom;
            for (int k = 0; k < $urandom_range(1, 2); k++) begin
               vec_t v;
               v       = mk(3'd0);
               v.instr = ins;
               push(v);
            end
         end else begin
            if (pick == 8) begin
               do op = 6'($urandom); while (is_legal(op));
            end else begin
               op = ops[pick];
            end
            ins = {op, 26'($urandom)};
            w   = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 4);
            gen_instr(ins, w, 1'($urandom), -1);
         end
      end
      stall_en = 1'b0;
      push(mk(3'd0));

      // Initial reset, then apply every row.
      reset           = 1'b1;
      bus.instr_in    = '0;
      bus.instr_valid = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.branch_cond = 1'b0;
      bus.stall_in    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      foreach (vq[i]) apply(vq[i]);

      hand_stall_mem();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
